// File: rtl/wam_pkg.sv
// Shared whack-a-mole types and default timing constants.
// Used by the mole controller, display and score blocks.
package wam_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    UP   = 2'd2,
    OVER = 2'd3
  } state_e;

  localparam int HOLE_IDX_W     = 4;
  localparam int NUM_HOLES_DEF  = 16;
  localparam int TICK_DIV_DEF   = 50000;
  localparam int UP_TICKS_DEF   = 40;
  localparam int GAP_TICKS_DEF  = 10;
  localparam int MAX_MISSES_DEF = 5;
  localparam int CNT_W_DEF      = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Game tick prescaler: counts 0..TICK_DIV-1, tick at the top.
// Ports: clk, rst_n (sync, active-low), restart_i (zero next cycle), tick_o.
module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = $clog2(TICK_DIV + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mole_ctrl.sv
// Mole controller: picks holes, times UP/GAP, counts hits and misses.
// Ports: clk, rst_n, rand_i[4:0], start, hit_btn, mole, score, misses, game_over, busy.
module mole_ctrl
  import wam_pkg::*;
#(
  parameter int NUM_HOLES  = NUM_HOLES_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int UP_TICKS   = UP_TICKS_DEF,
  parameter int GAP_TICKS  = GAP_TICKS_DEF,
  parameter int MAX_MISSES = MAX_MISSES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           rand_i,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] hit_btn,
  output logic [NUM_HOLES-1:0] mole,
  output logic [CNT_W-1:0]     score,
  output logic [CNT_W-1:0]     misses,
  output logic                 game_over,
  output logic                 busy
);

  localparam int MAXT = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
  localparam int TW   = $clog2(MAXT + 1);
  localparam logic [CNT_W-1:0] MAXM = CNT_W'(MAX_MISSES);

  state_e state_q, state_d;

  logic [NUM_HOLES-1:0]  mole_q, mole_d;
  logic [CNT_W-1:0]      score_q, score_d;
  logic [CNT_W-1:0]      misses_q, misses_d;
  logic                  over_q, over_d;
  logic                  busy_q, busy_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [HOLE_IDX_W-1:0] last_q, last_d;
  logic [NUM_HOLES-1:0]  btn_prev_q;

  logic                  tick;
  logic                  restart;
  logic                  gap_done;
  logic                  up_done;
  logic                  hit;
  logic [NUM_HOLES-1:0]  press;
  logic [HOLE_IDX_W-1:0] idx_raw;
  logic [HOLE_IDX_W-1:0] pick;
  logic [CNT_W-1:0]      miss_inc;
  logic                  rand_unused;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (restart),
    .tick_o    (tick)
  );

  assign rand_unused = rand_i[4];

  assign press    = hit_btn & ~btn_prev_q;
  assign hit      = press[last_q];
  assign gap_done = tick && (tcnt_q == TW'(GAP_TICKS - 1));
  assign up_done  = tick && (tcnt_q == TW'(UP_TICKS - 1));
  assign miss_inc = misses_q + CNT_W'(1);

  // Never light the same hole twice in a row.
  assign idx_raw = rand_i[HOLE_IDX_W-1:0];
  assign pick    = (idx_raw == last_q) ? idx_raw + HOLE_IDX_W'(1)
                                       : idx_raw;

  always_comb begin
    state_d  = state_q;
    mole_d   = mole_q;
    score_d  = score_q;
    misses_d = misses_q;
    last_d   = last_q;
    tcnt_d   = tick ? tcnt_q + TW'(1) : tcnt_q;
    unique case (state_q)
      IDLE: begin
        mole_d = '0;
        if (start) begin
          score_d  = '0;
          misses_d = '0;
          state_d  = GAP;
        end
      end
      GAP: begin
        mole_d = '0;
        if (gap_done) begin
          last_d  = pick;
          mole_d  = NUM_HOLES'(1) << pick;
          state_d = UP;
        end
      end
      UP: begin
        // A hit on the final tick takes priority over the miss.
        if (hit) begin
          if (score_q != '1) begin
            score_d = score_q + CNT_W'(1);
          end
          mole_d  = '0;
          state_d = GAP;
        end else if (up_done) begin
          misses_d = miss_inc;
          mole_d   = '0;
          state_d  = (miss_inc == MAXM) ? OVER : GAP;
        end
      end
      OVER: begin
        mole_d = '0;
        if (start) begin
          score_d  = '0;
          misses_d = '0;
          state_d  = GAP;
        end
      end
      default: begin
        mole_d  = '0;
        state_d = IDLE;
      end
    endcase
    restart = (state_d != state_q);
    if (restart) begin
      tcnt_d = '0;
    end
    over_d = (state_d == OVER);
    busy_d = (state_d == GAP) || (state_d == UP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mole_q     <= '0;
      score_q    <= '0;
      misses_q   <= '0;
      over_q     <= 1'b0;
      busy_q     <= 1'b0;
      tcnt_q     <= '0;
      last_q     <= '0;
      btn_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      mole_q     <= mole_d;
      score_q    <= score_d;
      misses_q   <= misses_d;
      over_q     <= over_d;
      busy_q     <= busy_d;
      tcnt_q     <= tcnt_d;
      last_q     <= last_d;
      btn_prev_q <= hit_btn;
    end
  end

  assign mole      = mole_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign game_over = over_q;
  assign busy      = busy_q;

endmodule
